// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM encoding, ACK/NACK levels, bit-counter width.
package i2c_pkg;

    localparam int BIT_CNT_W = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchronizer, optional stable-value filter (I2C_SLAVE_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection. One instance serves both lines.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("i2c_line_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic [CNT_W-1:0] scl_cnt;
    logic [CNT_W-1:0] sda_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl     <= 1'b1;
            sda     <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[SYNC_STAGES-1] == scl) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
                scl     <= scl_sync[SYNC_STAGES-1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + CNT_W'(1);
            end
            if (sda_sync[SYNC_STAGES-1] == sda) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
                sda     <= sda_sync[SYNC_STAGES-1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign scl = scl_sync[SYNC_STAGES-1];
    assign sda = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target on the system clock, no clock stretching.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
// state        | meaning
// IDLE         | bus free or not addressed since reset
// ADDR         | shifting address + R/W
// ADDR_ACK     | driving address ACK
// WR_DATA      | shifting a written byte
// WR_ACK       | driving data ACK
// RD_DATA      | driving read byte bits
// RD_ACK       | sampling master ACK/NACK
// WAIT_STOP    | not ours or read ended; wait for STOP/START
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h0F,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_match,
    output logic       busy,
    output logic       nack_rcvd
);

    i2c_state_e             state, state_n;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [7:0]             shreg, shreg_n;
    logic                   full, full_n;
    logic                   sda_low, sda_low_n;
    logic [7:0]             rx_data_n;
    logic                   rx_valid_n, addr_match_n, busy_n, nack_n;
    logic                   sda_in, scl_rise, scl_fall, start, stop;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_line_cond (
        .clk      (clk),
        .rst      (rst),
        .scl_pin  (SCL),
        .sda_pin  (SDA),
        .sda      (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign SDA = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            full       <= 1'b0;
            sda_low    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            nack_rcvd  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            full       <= full_n;
            sda_low    <= sda_low_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            addr_match <= addr_match_n;
            busy       <= busy_n;
            nack_rcvd  <= nack_n;
        end
    end

    // "full" marks that the 8th rising edge (or a read ACK) was seen, so the
    // following fall acts on the byte rather than on the fall right after START.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        full_n       = full;
        sda_low_n    = sda_low;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        addr_match_n = addr_match;
        busy_n       = busy;
        nack_n       = 1'b0;
        tx_req       = 1'b0;
        if (stop) begin
            state_n      = ST_IDLE;
            sda_low_n    = 1'b0;
            busy_n       = 1'b0;
            addr_match_n = 1'b0;
            full_n       = 1'b0;
        end else if (start) begin
            state_n      = ST_ADDR;
            sda_low_n    = 1'b0;
            busy_n       = 1'b1;
            addr_match_n = 1'b0;
            full_n       = 1'b0;
            bit_cnt_n    = '0;
        end else begin
            unique case (state)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[6:0], sda_in};
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == '1) begin
                            full_n = 1'b1;
                            if (state == ST_WR_DATA) begin
                                rx_data_n  = {shreg[6:0], sda_in};
                                rx_valid_n = 1'b1;
                            end
                        end
                    end else if (scl_fall && full) begin
                        full_n = 1'b0;
                        if (state == ST_WR_DATA) begin
                            sda_low_n = ~I2C_ACK;
                            state_n   = ST_WR_ACK;
                        end else if (shreg[7:1] == SLAVE_ADDR && shreg[7:1] != 7'd0) begin
                            sda_low_n    = ~I2C_ACK;
                            addr_match_n = 1'b1;
                            state_n      = ST_ADDR_ACK;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK, ST_RD_ACK: begin
                    if (state == ST_RD_ACK && scl_rise) begin
                        if (sda_in == I2C_NACK) begin
                            nack_n  = 1'b1;
                            state_n = ST_WAIT_STOP;
                        end else begin
                            full_n = 1'b1;
                        end
                    end else if (scl_fall && (state == ST_RD_ACK ? full : 1'b1)) begin
                        full_n    = 1'b0;
                        bit_cnt_n = '0;
                        if (state == ST_ADDR_ACK && !shreg[0]) begin
                            sda_low_n = 1'b0;
                            state_n   = ST_WR_DATA;
                        end else begin
                            tx_req    = 1'b1;
                            shreg_n   = tx_data;
                            sda_low_n = ~tx_data[7];
                            state_n   = ST_RD_DATA;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == '1) begin
                            sda_low_n = 1'b0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            shreg_n   = {shreg[6:0], 1'b0};
                            sda_low_n = ~shreg[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a behavioural bus master with hand-computed expectations.
module tb_i2c_slave;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addr_match, busy, nack_rcvd;
    wire        sda_bus;

    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave dut (
        .clk        (clk),
        .rst        (rst),
        .SCL        (scl_m),
        .SDA        (sda_bus),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .addr_match (addr_match),
        .busy       (busy),
        .nack_rcvd  (nack_rcvd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rxv    = 0;
    int n_txr    = 0;
    int n_nack   = 0;
    int n_am     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)   n_rxv++;
            if (tx_req)     n_txr++;
            if (nack_rcvd)  n_nack++;
            if (addr_match) n_am++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m_low = 1'b0; wait_clk(Q);
        scl_m     = 1'b1; wait_clk(Q);
        sda_m_low = 1'b1; wait_clk(Q);
        scl_m     = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m_low = 1'b1; wait_clk(Q);
        scl_m     = 1'b1; wait_clk(Q);
        sda_m_low = 1'b0; wait_clk(3 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m_low = ~b; wait_clk(Q);
        scl_m     = 1'b1; wait_clk(Q);
        s         = sda_bus; wait_clk(Q);
        scl_m     = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_out, output logic [7:0] d, output logic ack_seen);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(ack_out, ack_seen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rxv0, txr0, nack0, am0;

        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_busy", busy, 0);
        check("rst_nack", nack_rcvd, 0);
        check("rst_sda_released", sda_bus, 1);

        // write 0x0F <- 0xAB
        rxv0 = n_rxv;
        bus_start();
        check("wr_busy_after_start", busy, 1);
        write_byte(8'h1E, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addr_match", addr_match, 1);
        write_byte(8'hAB, ack);
        check("wr_data_ack", ack, 0);
        check("wr_busy_before_stop", busy, 1);
        bus_stop();
        check("wr_rx_data", rx_data, 8'hAB);
        check("wr_rx_valid_count", n_rxv - rxv0, 1);
        check("wr_busy_after_stop", busy, 0);
        check("wr_addr_match_after_stop", addr_match, 0);

        // wrong address 0x10
        rxv0 = n_rxv; am0 = n_am;
        bus_start();
        write_byte(8'h20, ack);
        check("miss_addr_nack", ack, 1);
        write_byte(8'h55, ack);
        check("miss_data_nack", ack, 1);
        check("miss_busy", busy, 1);
        bus_stop();
        check("miss_rx_valid_count", n_rxv - rxv0, 0);
        check("miss_addr_match_cycles", n_am - am0, 0);
        check("miss_rx_data_kept", rx_data, 8'hAB);

        // read 0x5A, master NACKs
        txr0 = n_txr; nack0 = n_nack;
        tx_data = 8'h5A;
        bus_start();
        write_byte(8'h1F, ack);
        check("rd_addr_ack", ack, 0);
        read_byte(1'b1, d, ack);
        check("rd_byte", d, 8'h5A);
        check("rd_sda_released_in_ack", ack, 1);
        check("rd_tx_req_count", n_txr - txr0, 1);
        check("rd_nack_count", n_nack - nack0, 1);
        bus_stop();
        check("rd_busy_after_stop", busy, 0);

        // two-byte read 0x11, 0x22
        txr0 = n_txr; nack0 = n_nack;
        tx_data = 8'h11;
        bus_start();
        write_byte(8'h1F, ack);
        check("rd2_addr_ack", ack, 0);
        sda_m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, ack);
            d[i] = ack;
        end
        check("rd2_byte1", d, 8'h11);
        tx_data = 8'h22;
        clock_bit(1'b0, ack);
        read_byte(1'b1, d, ack);
        check("rd2_byte2", d, 8'h22);
        check("rd2_tx_req_count", n_txr - txr0, 2);
        check("rd2_nack_count", n_nack - nack0, 1);
        bus_stop();

        // write 0xC3, repeated START, read 0x96
        tx_data = 8'h96;
        bus_start();
        write_byte(8'h1E, ack);
        check("rs_wr_addr_ack", ack, 0);
        write_byte(8'hC3, ack);
        check("rs_wr_data_ack", ack, 0);
        bus_start();
        check("rs_rx_data", rx_data, 8'hC3);
        check("rs_addr_match_cleared", addr_match, 0);
        check("rs_busy_held", busy, 1);
        write_byte(8'h1F, ack);
        check("rs_rd_addr_ack", ack, 0);
        read_byte(1'b1, d, ack);
        check("rs_rd_byte", d, 8'h96);
        bus_stop();

        // reset while the slave drives a 0 data bit
        tx_data = 8'h00;
        bus_start();
        write_byte(8'h1F, ack);
        check("rr_addr_ack", ack, 0);
        check("rr_sda_driven_low", sda_bus, 0);
        rst = 1'b1;
        wait_clk(1);
        check("rr_sda_released", sda_bus, 1);
        check("rr_busy", busy, 0);
        check("rr_addr_match", addr_match, 0);
        check("rr_rx_data", rx_data, 8'h00);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(Q);
        bus_stop();
        bus_start();
        write_byte(8'h1E, ack);
        check("rr_next_addr_ack", ack, 0);
        write_byte(8'h3C, ack);
        check("rr_next_data_ack", ack, 0);
        bus_stop();
        check("rr_next_rx_data", rx_data, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
